// File: rtl/mnist_inference_sequencer.sv
// Frame/start/result sequencer for the digit classifier: assembles the image, runs the classifier, holds the result.
// Optional BCD self-test bypass compiled in with `define MNIST_SEQ_BYPASS_TEST_EN.
module mnist_inference_sequencer #(
    parameter int unsigned ROWS    = 28,
    parameter int unsigned ROW_W   = 7,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ROW_W-1:0]        row_in,
    input  logic                    row_valid,
    input  logic                    host_ack,
    input  logic [3:0]              cls_digit,
    input  logic                    cls_valid,
    output logic [ROWS*ROW_W-1:0]   image_out,
    output logic                    cls_run,
    output logic                    cls_start,
    output logic [3:0]              result_bcd,
    output logic                    done,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned IMG_W  = ROWS * ROW_W;
    localparam int unsigned CNT_W  = $clog2(ROWS + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned IDX_W  = $clog2(IMG_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    row_cnt_q, row_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [IMG_W-1:0]    image_d;
    logic [3:0]          result_d;
    logic                done_d, busy_d, run_d, start_d, terr_d;
    logic [IDX_W-1:0]    row_base;

    // Bit offset of the row currently being written.
    assign row_base = IDX_W'(IDX_W'(row_cnt_q) * IDX_W'(ROW_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            image_out   <= '0;
            result_bcd  <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            cls_run     <= 1'b0;
            cls_start   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            image_out   <= image_d;
            result_bcd  <= result_d;
            done        <= done_d;
            busy        <= busy_d;
            cls_run     <= run_d;
            cls_start   <= start_d;
            timeout_err <= terr_d;
        end
    end

    // Next-state and next-output logic; registered outputs hold unless a state says otherwise.
    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        wait_cnt_d = wait_cnt_q;
        image_d    = image_out;
        result_d   = result_bcd;
        done_d     = done;
        run_d      = cls_run;
        start_d    = 1'b0;
        terr_d     = timeout_err;

        case (state_q)
            S_IDLE: begin
                if (row_valid) begin
                    image_d              = '0;
                    image_d[ROW_W-1:0]   = row_in;
                    row_cnt_d            = CNT_W'(1);
                    state_d              = S_LOAD;
                end
            end
            S_LOAD: begin
                if (row_valid) begin
                    image_d[row_base +: ROW_W] = row_in;
                    row_cnt_d                  = row_cnt_q + CNT_W'(1);
                    if (row_cnt_q == CNT_W'(ROWS - 1)) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
`ifdef MNIST_SEQ_BYPASS_TEST_EN
                if ((image_out[IMG_W-1:4] == '0) && (image_out[3:0] <= 4'd9)) begin
                    result_d = image_out[3:0];
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    start_d = 1'b1;
                    run_d   = 1'b1;
                    state_d = S_START;
                end
`else
                start_d = 1'b1;
                run_d   = 1'b1;
                state_d = S_START;
`endif
            end
            S_START: begin
                run_d      = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                run_d = 1'b1;
                // A valid result on the expiry cycle takes priority over the timeout.
                if (cls_valid) begin
                    result_d = cls_digit;
                    terr_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    result_d = 4'hF;
                    terr_d   = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_DONE: begin
                if (host_ack) begin
                    done_d  = 1'b0;
                    run_d   = 1'b0;
                    terr_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_mnist_inference_sequencer.sv
// Directed self-checking bench for mnist_inference_sequencer (TIMEOUT=16).
module tb_mnist_inference_sequencer;

    localparam int unsigned ROWS    = 28;
    localparam int unsigned ROW_W   = 7;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned IMG_W   = ROWS * ROW_W;

    logic               clk = 1'b0;
    logic               rst;
    logic [ROW_W-1:0]   row_in;
    logic               row_valid;
    logic               host_ack;
    logic [3:0]         cls_digit;
    logic               cls_valid;
    logic [IMG_W-1:0]   image_out;
    logic               cls_run;
    logic               cls_start;
    logic [3:0]         result_bcd;
    logic               done;
    logic               busy;
    logic               timeout_err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int s0;
    int n;
    logic [ROW_W-1:0] rows [ROWS];

    mnist_inference_sequencer #(
        .ROWS    (ROWS),
        .ROW_W   (ROW_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .row_valid   (row_valid),
        .host_ack    (host_ack),
        .cls_digit   (cls_digit),
        .cls_valid   (cls_valid),
        .image_out   (image_out),
        .cls_run     (cls_run),
        .cls_start   (cls_start),
        .result_bcd  (result_bcd),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cls_start) start_cnt = start_cnt + 1;
    end

    task automatic check(input string tag, input logic [IMG_W-1:0] act, input logic [IMG_W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IMG_W-1:0] exp_image();
        logic [IMG_W-1:0] img;
        img = '0;
        for (int i = 0; i < int'(ROWS); i++) img[i*ROW_W +: ROW_W] = rows[i];
        return img;
    endfunction

    // Sends all rows; returns one cycle after the last-row edge (CHECK cycle).
    task automatic send_frame(input bit gaps);
        for (int r = 0; r < int'(ROWS); r++) begin
            row_in    = rows[r];
            row_valid = 1'b1;
            tick();
            row_valid = 1'b0;
            if (gaps && (r % 2 == 0) && (r != int'(ROWS) - 1)) tick();
        end
    endtask

    task automatic ack();
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; row_in = '0; row_valid = 1'b0; host_ack = 1'b0;
        cls_digit = '0; cls_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_image", image_out, '0);
        check("rst_done", IMG_W'(done), '0);
        check("rst_busy", IMG_W'(busy), '0);
        check("rst_run", IMG_W'(cls_run), '0);
        check("rst_result", IMG_W'(result_bcd), '0);

        // Full frame of ones, classifier answers 7
        for (int r = 0; r < int'(ROWS); r++) rows[r] = 7'h7F;
        s0 = start_cnt;
        send_frame(1'b0);
        check("t1_check_busy", IMG_W'(busy), IMG_W'(1));
        check("t1_check_nostart", IMG_W'(cls_start), '0);
        tick();
        check("t1_start_e2", IMG_W'(cls_start), IMG_W'(1));
        check("t1_run", IMG_W'(cls_run), IMG_W'(1));
        tick();
        check("t1_start_drop", IMG_W'(cls_start), '0);
        tick(); tick();
        cls_valid = 1'b1; cls_digit = 4'd7;
        tick();
        cls_valid = 1'b0;
        check("t1_done", IMG_W'(done), IMG_W'(1));
        check("t1_result", IMG_W'(result_bcd), IMG_W'(7));
        check("t1_terr", IMG_W'(timeout_err), '0);
        check("t1_image", image_out, exp_image());
        check("t1_one_pulse", IMG_W'(start_cnt - s0), IMG_W'(1));
        ack();
        check("t1_ack_done", IMG_W'(done), '0);
        check("t1_ack_busy", IMG_W'(busy), '0);
        check("t1_ack_run", IMG_W'(cls_run), '0);

        // Small image: bypass path or normal start depending on build
        for (int r = 0; r < int'(ROWS); r++) rows[r] = '0;
        rows[0] = 7'h05;
        s0 = start_cnt;
        send_frame(1'b0);
        tick();
`ifdef MNIST_SEQ_BYPASS_TEST_EN
        check("t2_bypass_done", IMG_W'(done), IMG_W'(1));
        check("t2_bypass_result", IMG_W'(result_bcd), IMG_W'(5));
        tick();
        check("t2_bypass_nostart", IMG_W'(start_cnt - s0), '0);
`else
        check("t2_start", IMG_W'(cls_start), IMG_W'(1));
        check("t2_not_done", IMG_W'(done), '0);
        tick();
        cls_valid = 1'b1; cls_digit = 4'd2;
        tick();
        cls_valid = 1'b0;
        check("t2_done", IMG_W'(done), IMG_W'(1));
        check("t2_result", IMG_W'(result_bcd), IMG_W'(2));
`endif
        ack();

        // Gapped rows, stray row during WAIT, classifier silent -> timeout
        for (int r = 0; r < int'(ROWS); r++) rows[r] = ROW_W'(r + 1);
        send_frame(1'b1);
        tick();
        check("t3_start", IMG_W'(cls_start), IMG_W'(1));
        tick();
        row_valid = 1'b1; row_in = 7'h55;
        n = 0;
        while (!done && n < 40) begin
            tick();
            row_valid = 1'b0;
            n = n + 1;
        end
        check("t3_timeout_cycles", IMG_W'(n), IMG_W'(TIMEOUT));
        check("t3_result", IMG_W'(result_bcd), IMG_W'(4'hF));
        check("t3_terr", IMG_W'(timeout_err), IMG_W'(1));
        check("t3_image", image_out, exp_image());
        check("t3_run_held", IMG_W'(cls_run), IMG_W'(1));
        ack();
        check("t3_ack_terr", IMG_W'(timeout_err), '0);

        // cls_valid on the expiry cycle wins
        send_frame(1'b0);
        tick(); tick();
        repeat (TIMEOUT - 1) tick();
        check("t4_pre_expiry", IMG_W'(done), '0);
        cls_valid = 1'b1; cls_digit = 4'd3;
        tick();
        cls_valid = 1'b0;
        check("t4_done", IMG_W'(done), IMG_W'(1));
        check("t4_result", IMG_W'(result_bcd), IMG_W'(3));
        check("t4_terr", IMG_W'(timeout_err), '0);

        // Ack followed immediately by the next frame's first row
        ack();
        check("t5_ack_done", IMG_W'(done), '0);
        for (int r = 0; r < int'(ROWS); r++) rows[r] = ROW_W'(7'h40 | r);
        send_frame(1'b0);
        check("t5_result_held", IMG_W'(result_bcd), IMG_W'(3));
        check("t5_image", image_out, exp_image());
        tick(); tick();
        cls_valid = 1'b1; cls_digit = 4'd8;
        tick();
        cls_valid = 1'b0;
        check("t5_result", IMG_W'(result_bcd), IMG_W'(8));
        ack();

        // Reset after row 13 with a row on the reset edge, then a fresh frame
        for (int r = 0; r < 14; r++) begin
            row_in = 7'h7F; row_valid = 1'b1;
            tick();
        end
        rst = 1'b1; row_in = 7'h7F; row_valid = 1'b1;
        tick();
        rst = 1'b0; row_valid = 1'b0;
        check("t6_rst_image", image_out, '0);
        check("t6_rst_result", IMG_W'(result_bcd), '0);
        check("t6_rst_busy", IMG_W'(busy), '0);
        for (int r = 0; r < int'(ROWS); r++) rows[r] = '0;
        rows[ROWS-1] = 7'h2A;
        send_frame(1'b1);
        check("t6_image", image_out, exp_image());
        tick(); tick();
        cls_valid = 1'b1; cls_digit = 4'd9;
        tick();
        cls_valid = 1'b0;
        check("t6_done", IMG_W'(done), IMG_W'(1));
        check("t6_result", IMG_W'(result_bcd), IMG_W'(9));
        ack();
        check("t6_ack_done", IMG_W'(done), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
